// File: rtl/match_pkg.sv
// match_pkg: shared definitions for the match_feeder sequencing front end.
//   feeder_state_t : FSM state encoding
//   BYTE_W, POS_W  : byte width and default text-position width
//   fold_case()    : ASCII upper-to-lower conversion (A-Z -> a-z)
package match_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned POS_W  = 15;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PAT,
        PAT_GAP,
        TEXT,
        TEXT_GAP,
        FINISH
    } feeder_state_t;

    function automatic logic [BYTE_W-1:0] fold_case(input logic [BYTE_W-1:0] b);
        if (b >= 8'h41 && b <= 8'h5A) begin
            return b | 8'h20;
        end
        return b;
    endfunction

endpackage

// File: rtl/match_feeder.sv
// match_feeder: loads a pattern from an upstream byte stream, then streams
// text bytes to the matcher with GAP_CYCLES idle cycles after every byte.
//
// Parameters: PAT_MAX_LEN (max pattern bytes), GAP_CYCLES (0..15),
//             POS_W (text length / byte counter width).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : command pulse, samples pat_len / text_len
//   pat_len, text_len : run lengths in bytes
//   s_data/s_valid/s_ready : upstream byte handshake (s_ready is a state decode)
//   pattern/pattern_val    : pattern byte to the matcher
//   data_in/data_in_val    : text byte to the matcher
//   done, match_end   : pattern-load-complete / text-complete pulses
//   busy, err         : not-IDLE flag / rejected-start pulse
//   byte_cnt          : text bytes sent in the current run
// Build option: define MATCH_FEEDER_CASEFOLD_EN to fold A-Z to a-z on both
// byte outputs (folding happens ahead of the output registers).
module match_feeder #(
    parameter int unsigned PAT_MAX_LEN = 16,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned POS_W       = match_pkg::POS_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [$clog2(PAT_MAX_LEN+1)-1:0]     pat_len,
    input  logic [POS_W-1:0]                     text_len,
    input  logic [match_pkg::BYTE_W-1:0]         s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [match_pkg::BYTE_W-1:0]         pattern,
    output logic                                 pattern_val,
    output logic [match_pkg::BYTE_W-1:0]         data_in,
    output logic                                 data_in_val,
    output logic                                 done,
    output logic                                 match_end,
    output logic                                 busy,
    output logic                                 err,
    output logic [POS_W-1:0]                     byte_cnt
);
    import match_pkg::*;

    localparam int unsigned PLW = $clog2(PAT_MAX_LEN+1);
    // Gap counter is loaded with GAP_CYCLES-1 and counts down to zero.
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    feeder_state_t        state, next_state;
    logic [PLW-1:0]       pat_len_q, pat_cnt;
    logic [POS_W-1:0]     text_len_q;
    logic [3:0]           gap_cnt;
    logic [BYTE_W-1:0]    s_byte;
    logic                 xfer, start_ok, pat_last, text_last;

`ifdef MATCH_FEEDER_CASEFOLD_EN
    assign s_byte = fold_case(s_data);
`else
    assign s_byte = s_data;
`endif

    assign xfer      = s_valid & s_ready;
    assign start_ok  = start && (pat_len != '0) && (pat_len <= PLW'(PAT_MAX_LEN));
    assign pat_last  = (PLW'(pat_cnt + 1'b1) == pat_len_q);
    assign text_last = (POS_W'(byte_cnt + 1'b1) == text_len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) next_state = LOAD_PAT;
            end
            LOAD_PAT: begin
                s_ready = 1'b1;
                if (xfer && pat_last) next_state = PAT_GAP;
            end
            PAT_GAP: begin
                next_state = (text_len_q == '0) ? FINISH : TEXT;
            end
            TEXT: begin
                s_ready = 1'b1;
                if (xfer) begin
                    if (GAP_CYCLES > 0)  next_state = TEXT_GAP;
                    else if (text_last)  next_state = FINISH;
                end
            end
            TEXT_GAP: begin
                if (gap_cnt == '0)
                    next_state = (byte_cnt == text_len_q) ? FINISH : TEXT;
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // done/match_end are registered decodes of PAT_GAP/FINISH, so each lands
    // one cycle after its state; busy tracks next_state so it mirrors state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern     <= '0;
            pattern_val <= 1'b0;
            data_in     <= '0;
            data_in_val <= 1'b0;
            done        <= 1'b0;
            match_end   <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            byte_cnt    <= '0;
            pat_len_q   <= '0;
            pat_cnt     <= '0;
            text_len_q  <= '0;
            gap_cnt     <= '0;
        end else begin
            pattern_val <= 1'b0;
            data_in_val <= 1'b0;
            done        <= (state == PAT_GAP);
            match_end   <= (state == FINISH);
            busy        <= (next_state != IDLE);
            err         <= (state == IDLE) && start && !start_ok;

            if (state == IDLE && start_ok) begin
                pat_len_q  <= pat_len;
                text_len_q <= text_len;
                byte_cnt   <= '0;
                pat_cnt    <= '0;
            end

            if (state == LOAD_PAT && xfer) begin
                pattern     <= s_byte;
                pattern_val <= 1'b1;
                pat_cnt     <= PLW'(pat_cnt + 1'b1);
            end

            if (state == TEXT && xfer) begin
                data_in     <= s_byte;
                data_in_val <= 1'b1;
                if (byte_cnt != text_len_q) byte_cnt <= POS_W'(byte_cnt + 1'b1);
                gap_cnt     <= GAP_LAST;
            end

            if (state == TEXT_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_match_feeder.sv
module tb_match_feeder;

    logic        clk = 1'b0;
    logic        rst, start, s_valid, s_ready;
    logic [4:0]  pat_len;
    logic [14:0] text_len;
    logic [7:0]  s_data, pattern, data_in;
    logic        pattern_val, data_in_val, done, match_end, busy, err;
    logic [14:0] byte_cnt;

    always #5 clk = ~clk;

    match_feeder #(.PAT_MAX_LEN(16), .GAP_CYCLES(2), .POS_W(15)) dut (
        .clk(clk), .rst(rst), .start(start), .pat_len(pat_len), .text_len(text_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .pattern(pattern), .pattern_val(pattern_val),
        .data_in(data_in), .data_in_val(data_in_val),
        .done(done), .match_end(match_end), .busy(busy), .err(err), .byte_cnt(byte_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_b(input logic [7:0] b);
`ifdef MATCH_FEEDER_CASEFOLD_EN
        if (b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
`endif
        return b;
    endfunction

    logic [7:0] exp_pat[$];
    logic [7:0] exp_dat[$];
    int cyc = 0;
    int last_pat, last_data, done_cyc, data_cnt, cur_text_len;
    int done_cnt = 0, me_cnt = 0, err_cnt = 0;
    bit chk_rate;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (pattern_val) begin
                if (exp_pat.size() == 0) check("pat_extra", 1, 0);
                else check("pattern", pattern, exp_pat.pop_front());
                if (chk_rate && last_pat >= 0) check("pat_rate", cyc - last_pat, 1);
                last_pat = cyc;
            end
            if (data_in_val) begin
                if (exp_dat.size() == 0) check("data_extra", 1, 0);
                else check("data_in", data_in, exp_dat.pop_front());
                if (chk_rate && last_data >= 0) check("data_rate", cyc - last_data, 3);
                last_data = cyc;
                data_cnt++;
            end
            if (done) begin
                check("done_lat", cyc - last_pat, 1);
                done_cyc = cyc;
                done_cnt++;
            end
            if (match_end) begin
                if (cur_text_len == 0) check("me_after_done", cyc - done_cyc, 1);
                else check("me_lat", cyc - last_data, 3);
                me_cnt++;
            end
            if (err) err_cnt++;
        end
    end

    // Called right after a posedge (+1); samples s_ready on the negedge
    // before each edge so the transfer edge is known exactly.
    task automatic send_byte(input logic [7:0] b, input bit is_pat);
        int n = 0;
        bit ok = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            n++;
        end
        if (!ok) check("s_ready_timeout", 0, 1);
        else if (is_pat) exp_pat.push_back(exp_b(b));
        else exp_dat.push_back(exp_b(b));
        #1 s_valid = 1'b0;
    endtask

    task automatic stall2();
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string ph);
        check({ph, "_pattern"},     pattern, 0);
        check({ph, "_pattern_val"}, pattern_val, 0);
        check({ph, "_data_in"},     data_in, 0);
        check({ph, "_data_in_val"}, data_in_val, 0);
        check({ph, "_done"},        done, 0);
        check({ph, "_match_end"},   match_end, 0);
        check({ph, "_busy"},        busy, 0);
        check({ph, "_err"},         err, 0);
        check({ph, "_byte_cnt"},    byte_cnt, 0);
        check({ph, "_s_ready"},     s_ready, 0);
    endtask

    task automatic run(input string pat, input string txt, input bit stall,
                       input int inject_at, input int abort_at);
        int me0, n;
        last_pat = -1; last_data = -1; data_cnt = 0;
        chk_rate = !stall;
        cur_text_len = txt.len();
        me0 = me_cnt;
        start = 1'b1; pat_len = 5'(pat.len()); text_len = 15'(txt.len());
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("busy_rise", busy, 1);
        @(posedge clk); #1;
        for (int i = 0; i < pat.len(); i++) begin
            if (stall && (i % 2 == 1)) stall2();
            send_byte(pat[i], 1'b1);
        end
        for (int i = 0; i < txt.len(); i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                check_reset_outputs("midrst");
                exp_pat.delete(); exp_dat.delete();
                repeat (10) @(posedge clk);
                check("no_me_after_rst", me_cnt, me0);
                #1;
                return;
            end
            if (i == inject_at) begin
                start = 1'b1; pat_len = 5'd3; text_len = 15'd5;
                @(posedge clk); #1 start = 1'b0;
            end
            if (stall && (i % 2 == 1)) stall2();
            send_byte(txt[i], 1'b0);
        end
        n = 0;
        while (me_cnt == me0 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        check("match_end_seen", me_cnt - me0, 1);
        check("byte_cnt_final", byte_cnt, txt.len());
        check("data_pulses", data_cnt, txt.len());
        check("busy_fall", busy, 0);
        check("pat_q_empty", exp_pat.size(), 0);
        check("dat_q_empty", exp_dat.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic reject(input int len);
        start = 1'b1; pat_len = 5'(len); text_len = 15'd4;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("rej_err", err, 1);
        check("rej_busy", busy, 0);
        @(negedge clk);
        check("rej_err_clear", err, 0);
        check("rej_busy_stay", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int e0;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        pat_len = '0; text_len = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;

        run("abcab", "ababcabcabbadabcaccacd", 1'b0, -1, -1);
        run("abcab", "hello world", 1'b1, -1, -1);
        reject(0);
        reject(17);
        e0 = err_cnt;
        run("abc", "ababcabcabbadabcaccacd", 1'b0, 4, -1);
        check("start_ignored_err", err_cnt, e0);
        run("ab", "ababcabcabbadabcaccacd", 1'b0, -1, 7);
        run("q", "", 1'b0, -1, -1);
        run("Ab", "AbC", 1'b0, -1, -1);
        check("done_total", done_cnt, 6);
        check("me_total", me_cnt, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
